// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter; define UART_TX_PARITY_EN to add an even-parity bit.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          rs232_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CW = BAUD_DIV > 1 ? $clog2(BAUD_DIV) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
  logic par;
`endif
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          tx_q;
  logic          push, pop, bit_done, has_data;
  assign tx_ready   = count != (AW+1)'(FIFO_DEPTH);
  assign has_data   = count != '0;
  assign bit_done   = cnt == CW'(BAUD_DIV - 1);
  assign push       = tx_valid && tx_ready;
  assign pop        = has_data && (state == IDLE || (state == STOP && bit_done));
  assign rs232_tx   = tx_q;
  assign tx_busy    = state != IDLE;
  assign fifo_count = count;
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  // The line bit is always a registered value, so rs232_tx cannot glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      tx_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      cnt <= (state == IDLE || bit_done) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          tx_q <= !pop;
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= START;
`ifdef UART_TX_PARITY_EN
            par   <= ^mem[rd_ptr];
`endif
          end
        end
        START: if (bit_done) begin
          tx_q  <= shift[0];
          idx   <= '0;
          state <= DATA;
        end
        DATA: if (bit_done) begin
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_q  <= par;
            state <= PARITY;
`else
            tx_q  <= 1'b1;
            state <= STOP;
`endif
          end else begin
            shift <= shift >> 1;
            tx_q  <= shift[1];
            idx   <= idx + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (bit_done) begin
          tx_q  <= 1'b1;
          state <= STOP;
        end
`endif
        STOP: if (bit_done) begin
          tx_q <= !pop;
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= START;
`ifdef UART_TX_PARITY_EN
            par   <= ^mem[rd_ptr];
`endif
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
